uart_frame_ctrl: RTL and testbench
==================================

// Module: uart_frame_ctrl
// PURPOSE
//  Sequences the byte stream from the UART receiver into framed register-write commands.
//  Hunts for a sync byte, collects address/length/payload/checksum, and validates the frame.
//  Replays a good payload as single-cycle writes into the frame register file.
//  Sits between the UART Rx byte output (data + readiness strobe) and the register bank.
// PARAMETERS
//  SYNC_BYTE    8'hA5    frame start marker
//  MAX_LEN      16       max payload bytes per frame (power of 2, 2..64)
//  TIMEOUT_CYC  200000   idle clk_Rx cycles allowed between bytes inside a frame (2 ms @100 MHz)
// PORTS
//  clk_Rx      in   1   system clock, 100 MHz
//  rst_n       in   1   asynchronous active-low reset
//  byte_in     in   8   received byte; valid while byte_rdy is high
//  byte_rdy    in   1   readiness level from the UART receiver; may stay high for several cycles
//  reg_we      out  1   register write strobe, one cycle per payload byte
//  reg_addr    out  8   register write address
//  reg_data    out  8   register write data
//  busy        out  1   high in any state other than IDLE
//  frame_ok    out  1   1-cycle pulse: frame written completely
//  frame_err   out  1   1-cycle pulse: checksum, length or timeout error
//  err_code    out  2   cause of the last error, held until the next error: 01 chk, 10 len, 11 timeout
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0, buffer contents don't-care.
//  - Byte accept: rising edge of byte_rdy (registered previous value) -> accept = 1 for one cycle; byte_in is sampled that cycle.
//    A level held high counts once.
//  - Frame: SYNC, ADDR, LEN, DATA[0..LEN-1], CHK. CHK = ADDR ^ LEN ^ DATA[0] ^ ... ^ DATA[LEN-1].
//  - FSM states: IDLE, ADDR, LEN, DATA, CHK, WRITE, ERR.
//    IDLE : accept & byte==SYNC_BYTE -> ADDR. Other bytes are dropped silently.
//    ADDR : accept -> latch base address, chk = byte -> LEN.
//    LEN  : accept -> LEN==0 or LEN>MAX_LEN ? ERR(code 10) : latch LEN, chk ^= byte, idx = 0 -> DATA.
//    DATA : accept -> buf[idx] = byte, chk ^= byte, idx++. After the LEN-th byte -> CHK.
//    CHK  : accept -> byte==chk ? (idx = 0 -> WRITE) : ERR(code 01).
//    WRITE: each cycle reg_we = 1, reg_addr = base + idx (mod 256, wraps 8'hFF -> 8'h00), reg_data = buf[idx], idx++.
//           After LEN writes, frame_ok pulses in the cycle after the last reg_we -> IDLE.
//    ERR  : frame_err = 1, err_code updated, one cycle -> IDLE.
//  - Write latency: first reg_we occurs 1 cycle after the cycle the CHK byte is accepted.
//    Writes are back-to-back; there is no backpressure.
//  - Timeout: the counter clears on every accept and in IDLE/WRITE/ERR.
//    In ADDR..CHK, reaching TIMEOUT_CYC -> ERR(code 11).
//  - A SYNC value inside ADDR/LEN/DATA/CHK is ordinary data; there is no resync mid-frame.
//  - Accepts arriving during WRITE or ERR are dropped. At 9600 baud this cannot occur for a real stream.
//  - Timeout reaching its limit in the same cycle as an accept: the accept wins and the counter clears.
//  - Async reset mid-frame or mid-WRITE aborts immediately. No partial frame_ok; the next reg_we cannot appear before a new full frame.
//  - Only the rising edge of byte_rdy after reset counts; a level already high at reset release is not an accept.
// STRUCTURE
//  - Shared package (uart_frame_pkg): state encoding localparams, err_code constants, default SYNC_BYTE.
//  - One sub-module, uart_frame_buf: MAX_LEN x 8 single-port buffer, write in DATA, read in WRITE.
//    Registered address, combinational read so reg_data aligns with reg_we.
//  - Edge detect, checksum, timeout counter and FSM live in the top module.
// TESTING
//  1 Good frame A5 10 03 11 22 33 (chk 10^03^11^22^33 = 13) -> writes 10:11, 11:22, 12:33 on consecutive cycles, then one frame_ok pulse.
//  2 Same frame with chk 14 -> no reg_we; one frame_err pulse; err_code = 01.
//  3 LEN = 0 and LEN = MAX_LEN+1 -> frame_err, err_code = 10, back in IDLE; a following good frame is written.
//  4 Stop after A5 20 02 AA with no more bytes -> frame_err at TIMEOUT_CYC, err_code = 11.
//    Check that garbage bytes 00 FF before SYNC are ignored.
//  5 ADDR = FE, LEN = 3, data 01 02 03 -> writes FE:01, FF:02, 00:03 (address wrap).
//    Check byte_rdy held high 2 cycles per byte yields no duplicate bytes.
//  6 Assert rst_n low during WRITE of a 4-byte frame -> reg_we = 0 at once.
//    After release, byte_rdy already high does not accept; a new good frame writes normally.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame controller: state encoding, error codes,
// default sync marker.
package uart_frame_pkg;
  localparam int         DATA_W       = 8;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_LEN   = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_CHK   = 3'd4;
  localparam state_t ST_WRITE = 3'd5;
  localparam state_t ST_ERR   = 3'd6;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;
endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: written one byte per accept while collecting DATA, read back
// combinationally during WRITE so reg_data lines up with reg_we.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_Rx,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_Rx)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

// File: rtl/uart_frame_ctrl.sv
// Turns the UART Rx byte stream into framed register writes:
// SYNC, ADDR, LEN, DATA[LEN], CHK (xor of ADDR..DATA), then LEN back-to-back writes.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 200000
) (
  input  logic       clk_Rx,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_rdy,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);
  localparam int         IW       = $clog2(MAX_LEN);
  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  state_t          state, state_nx;
  logic [1:0]      err_nx;
  logic            rdy_q, accept, in_frame, tmo_hit, len_bad;
  logic [IW-1:0]   idx, len_m1;
  logic [7:0]      base, chk, buf_rdata;
  logic [TW-1:0]   tmo_cnt;

  // rdy_q resets high so a level already asserted at reset release is not an edge
  always_ff @(posedge clk_Rx or negedge rst_n)
    if (!rst_n) rdy_q <= 1'b1;
    else        rdy_q <= byte_rdy;

  assign accept   = byte_rdy & ~rdy_q;
  assign in_frame = (state == ST_ADDR) || (state == ST_LEN) ||
                    (state == ST_DATA) || (state == ST_CHK);
  assign tmo_hit  = in_frame && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign len_bad  = (byte_in == 8'd0) || (byte_in > MAX_LEN8);

  always_ff @(posedge clk_Rx or negedge rst_n)
    if (!rst_n)                   tmo_cnt <= '0;
    else if (accept || !in_frame) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + TW'(1);

  always_ff @(posedge clk_Rx or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    err_nx   = err_code;
    case (state)
      ST_IDLE:  if (accept && byte_in == SYNC_BYTE) state_nx = ST_ADDR;
      ST_ADDR:  if (accept) state_nx = ST_LEN;
      ST_LEN:   if (accept) begin
                  if (len_bad) begin state_nx = ST_ERR; err_nx = ERR_LEN; end
                  else state_nx = ST_DATA;
                end
      ST_DATA:  if (accept && idx == len_m1) state_nx = ST_CHK;
      ST_CHK:   if (accept) begin
                  if (byte_in == chk) state_nx = ST_WRITE;
                  else begin state_nx = ST_ERR; err_nx = ERR_CHK; end
                end
      ST_WRITE: if (idx == len_m1) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    // an accept in the same cycle as the limit keeps the frame alive
    if (tmo_hit && !accept) begin
      state_nx = ST_ERR;
      err_nx   = ERR_TMO;
    end
  end

  always_ff @(posedge clk_Rx or negedge rst_n)
    if (!rst_n) begin
      idx      <= '0;
      len_m1   <= '0;
      base     <= '0;
      chk      <= '0;
      frame_ok <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      frame_ok <= (state == ST_WRITE) && (idx == len_m1);
      err_code <= err_nx;
      case (state)
        ST_ADDR:  if (accept) begin base <= byte_in; chk <= byte_in; end
        ST_LEN:   if (accept) begin
                    len_m1 <= IW'(byte_in - 8'd1);
                    chk    <= chk ^ byte_in;
                    idx    <= '0;
                  end
        ST_DATA:  if (accept) begin chk <= chk ^ byte_in; idx <= idx + IW'(1); end
        ST_CHK:   if (accept) idx <= '0;
        ST_WRITE: idx <= idx + IW'(1);
        default:  ;
      endcase
    end

  uart_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk_Rx (clk_Rx),
    .we     ((state == ST_DATA) && accept),
    .addr   (idx),
    .wdata  (byte_in),
    .rdata  (buf_rdata)
  );

  always_comb begin
    reg_we    = 1'b0;
    reg_addr  = 8'h00;
    reg_data  = 8'h00;
    frame_err = (state == ST_ERR);
    busy      = (state != ST_IDLE);
    if (state == ST_WRITE) begin
      reg_we   = 1'b1;
      reg_addr = base + 8'(idx);
      reg_data = buf_rdata;
    end
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Randomized bench for uart_frame_ctrl; expectations come from a frame-level
// model (address wrap, xor checksum, length rules) rather than the FSM.
module tb_uart_frame_ctrl;
  localparam int MAX_LEN = 16;
  localparam int TMO     = 300;

  logic       clk_Rx = 1'b0, rst_n = 1'b0, byte_rdy = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       reg_we, busy, frame_ok, frame_err;
  logic [7:0] reg_addr, reg_data;
  logic [1:0] err_code;

  int chk_n = 0, err_n = 0;
  int cyc = 0, last_raise = 0;
  int n_w, first_we, last_we, ok_n, ok_cyc, err_p, err_cyc;
  logic [1:0] err_seen;
  string obs_s, exp_s;
  int exp_ok, exp_err;
  logic [1:0] exp_code = 2'b00;
  logic [7:0] pay[$];

  uart_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk_Rx(clk_Rx), .rst_n(rst_n), .byte_in(byte_in), .byte_rdy(byte_rdy),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data), .busy(busy),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk_Rx = ~clk_Rx;
  always @(posedge clk_Rx) cyc <= cyc + 1;

  always @(negedge clk_Rx) begin
    if (reg_we) begin
      if (n_w == 0) first_we = cyc;
      last_we = cyc;
      n_w++;
      obs_s = {obs_s, $sformatf("%02h:%02h ", reg_addr, reg_data)};
    end
    if (frame_ok) begin ok_n++; ok_cyc = cyc; end
    if (frame_err) begin err_p++; err_cyc = cyc; err_seen = err_code; end
  end

  task automatic clear_obs();
    n_w = 0; ok_n = 0; err_p = 0; obs_s = "";
    first_we = -1; last_we = -1; ok_cyc = -1; err_cyc = -1; err_seen = 2'b00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk_Rx); #1;
    byte_in = b; byte_rdy = 1'b1; last_raise = cyc;
    repeat (hold) @(posedge clk_Rx);
    #1 byte_rdy = 1'b0; byte_in = 8'($urandom);
    repeat ($urandom_range(1, 4)) @(posedge clk_Rx);
  endtask

  // Reference model + driver: expectations derived from the frame rules, then bytes sent.
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] len,
                            input logic [7:0] chk_flip, input int hold);
    logic [7:0] c;
    bit len_ok;
    clear_obs();
    len_ok = (len != 8'd0) && (int'(len) <= MAX_LEN);
    c = addr ^ len;
    foreach (pay[i]) c ^= pay[i];
    exp_s = ""; exp_ok = 0; exp_err = 0;
    if (!len_ok) begin exp_err = 1; exp_code = 2'b10; end
    else if (chk_flip != 8'h00) begin exp_err = 1; exp_code = 2'b01; end
    else begin
      exp_ok = 1;
      for (int i = 0; i < int'(len); i++)
        exp_s = {exp_s, $sformatf("%02h:%02h ", 8'(addr + i), pay[i])};
    end
    send_byte(8'hA5, hold);
    send_byte(addr, hold);
    send_byte(len, hold);
    if (len_ok) begin
      foreach (pay[i]) send_byte(pay[i], hold);
      send_byte(c ^ chk_flip, hold);
    end
    repeat (int'(len) + 6) @(posedge clk_Rx);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; byte_rdy = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk_Rx);
    #1;
    chk_n++; if ({reg_we, busy, frame_ok, frame_err} !== 4'b0000) begin err_n++;
      $display("FAIL reset_strobes: got %b want 0000", {reg_we, busy, frame_ok, frame_err}); end
    chk_n++; if (err_code !== 2'b00) begin err_n++;
      $display("FAIL reset_err_code: got %b want 00", err_code); end
    chk_n++; if ({reg_addr, reg_data} !== 16'h0000) begin err_n++;
      $display("FAIL reset_addr_data: got %h want 0000", {reg_addr, reg_data}); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk_Rx);
    #1;
    chk_n++; if (busy !== 1'b0) begin err_n++;
      $display("FAIL reset_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_good_frame();
    pay = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 8'h03, 8'h00, 1);
    chk_n++; if (obs_s != exp_s) begin err_n++;
      $display("FAIL good_writes: got '%s' want '%s'", obs_s, exp_s); end
    chk_n++; if (first_we != last_raise + 1) begin err_n++;
      $display("FAIL good_latency: first write cycle %0d want %0d", first_we, last_raise + 1); end
    chk_n++; if (last_we - first_we + 1 != 3) begin err_n++;
      $display("FAIL good_back_to_back: span %0d want 3", last_we - first_we + 1); end
    chk_n++; if (ok_n != 1 || ok_cyc != last_we + 1) begin err_n++;
      $display("FAIL good_frame_ok: pulses %0d at %0d want 1 at %0d", ok_n, ok_cyc, last_we + 1); end
    chk_n++; if (err_p != 0 || busy !== 1'b0) begin err_n++;
      $display("FAIL good_idle: err pulses %0d busy %b want 0 0", err_p, busy); end
  endtask

  task automatic test_bad_chk();
    pay = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 8'h03, 8'h07, 1);
    chk_n++; if (n_w != 0 || ok_n != 0) begin err_n++;
      $display("FAIL badchk_no_write: writes %0d ok %0d want 0 0", n_w, ok_n); end
    chk_n++; if (err_p != 1 || err_seen !== 2'b01) begin err_n++;
      $display("FAIL badchk_err: pulses %0d code %b want 1 01", err_p, err_seen); end
    chk_n++; if (err_code !== exp_code) begin err_n++;
      $display("FAIL badchk_code_held: got %b want %b", err_code, exp_code); end
  endtask

  task automatic test_bad_len();
    logic [7:0] lens [2];
    lens[0] = 8'd0; lens[1] = 8'(MAX_LEN + 1);
    pay.delete();
    for (int k = 0; k < 2; k++) begin
      send_frame(8'h20, lens[k], 8'h00, 1);
      chk_n++; if (err_p != 1 || err_seen !== 2'b10 || n_w != 0) begin err_n++;
        $display("FAIL badlen_%0d: pulses %0d code %b writes %0d want 1 10 0", lens[k], err_p, err_seen, n_w); end
      chk_n++; if (busy !== 1'b0) begin err_n++;
        $display("FAIL badlen_idle_%0d: busy %b want 0", lens[k], busy); end
    end
    pay.delete();
    repeat (5) pay.push_back(8'($urandom));
    send_frame(8'($urandom), 8'd5, 8'h00, 1);
    chk_n++; if (obs_s != exp_s || ok_n != 1) begin err_n++;
      $display("FAIL badlen_recover: got '%s' ok %0d want '%s' ok 1", obs_s, ok_n, exp_s); end
    chk_n++; if (err_code !== 2'b10) begin err_n++;
      $display("FAIL badlen_code_held: got %b want 10", err_code); end
  endtask

  task automatic test_timeout();
    int t0;
    clear_obs();
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    #1;
    chk_n++; if (busy !== 1'b0) begin err_n++;
      $display("FAIL tmo_garbage: busy %b want 0", busy); end
    send_byte(8'hA5, 1); send_byte(8'h20, 1); send_byte(8'h02, 1); send_byte(8'hAA, 1);
    t0 = last_raise;
    #1;
    chk_n++; if (busy !== 1'b1) begin err_n++;
      $display("FAIL tmo_busy: busy %b want 1", busy); end
    for (int i = 0; i < TMO + 40 && err_p == 0; i++) @(posedge clk_Rx);
    repeat (3) @(posedge clk_Rx);
    #1;
    chk_n++; if (err_cyc < t0 + TMO - 2 || err_cyc > t0 + TMO + 3) begin err_n++;
      $display("FAIL tmo_time: frame_err at %0d want near %0d", err_cyc, t0 + TMO + 1); end
    chk_n++; if (err_p != 1 || err_seen !== 2'b11 || err_code !== 2'b11) begin err_n++;
      $display("FAIL tmo_code: pulses %0d code %b/%b want 1 11/11", err_p, err_seen, err_code); end
    chk_n++; if (n_w != 0 || busy !== 1'b0) begin err_n++;
      $display("FAIL tmo_idle: writes %0d busy %b want 0 0", n_w, busy); end
    exp_code = 2'b11;
  endtask

  task automatic test_wrap();
    pay = '{8'h01, 8'h02, 8'h03};
    send_frame(8'hFE, 8'h03, 8'h00, 2);
    chk_n++; if (obs_s != exp_s || obs_s != "fe:01 ff:02 00:03 ") begin err_n++;
      $display("FAIL wrap_writes: got '%s' want '%s'", obs_s, exp_s); end
    chk_n++; if (ok_n != 1 || err_p != 0) begin err_n++;
      $display("FAIL wrap_status: ok %0d err %0d want 1 0", ok_n, err_p); end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] c;
    clear_obs();
    pay.delete();
    repeat (4) pay.push_back(8'($urandom));
    c = 8'h40 ^ 8'h04;
    send_byte(8'hA5, 1); send_byte(8'h40, 1); send_byte(8'h04, 1);
    foreach (pay[i]) begin send_byte(pay[i], 1); c ^= pay[i]; end
    @(posedge clk_Rx); #1;
    byte_in = c; byte_rdy = 1'b1;
    repeat (3) @(posedge clk_Rx);
    #2;
    chk_n++; if (reg_we !== 1'b1) begin err_n++;
      $display("FAIL rstw_in_write: reg_we %b want 1", reg_we); end
    rst_n = 1'b0;
    #1;
    chk_n++; if (reg_we !== 1'b0 || busy !== 1'b0) begin err_n++;
      $display("FAIL rstw_abort: reg_we %b busy %b want 0 0", reg_we, busy); end
    byte_in = 8'hA5;
    repeat (3) @(posedge clk_Rx);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk_Rx);
    #1;
    chk_n++; if (busy !== 1'b0 || n_w != 2 || ok_n != 0 || err_p != 0) begin err_n++;
      $display("FAIL rstw_after: busy %b writes %0d ok %0d err %0d want 0 2 0 0", busy, n_w, ok_n, err_p); end
    byte_rdy = 1'b0;
    exp_code = 2'b00;
    send_frame(8'($urandom), 8'd4, 8'h00, 1);
    chk_n++; if (obs_s != exp_s || ok_n != 1) begin err_n++;
      $display("FAIL rstw_new_frame: got '%s' ok %0d want '%s' ok 1", obs_s, ok_n, exp_s); end
  endtask

  task automatic test_random();
    int kind, len, hold;
    logic [7:0] a, g, flip;
    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(0, 2);
      hold = $urandom_range(1, 3);
      a    = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, hold);
      end
      pay.delete();
      if (kind == 2) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
      else begin
        len = $urandom_range(1, MAX_LEN);
        repeat (len) pay.push_back(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom));
      end
      flip = (kind == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(a, 8'(len), flip, hold);
      chk_n++; if (obs_s != exp_s) begin err_n++;
        $display("FAIL rand%0d_writes: got '%s' want '%s'", f, obs_s, exp_s); end
      chk_n++; if (ok_n != exp_ok || err_p != exp_err || err_code !== exp_code) begin err_n++;
        $display("FAIL rand%0d_status: ok %0d err %0d code %b want %0d %0d %b",
                 f, ok_n, err_p, err_code, exp_ok, exp_err, exp_code); end
      if (exp_ok == 1) begin
        chk_n++; if (last_we - first_we + 1 != n_w || ok_cyc != last_we + 1) begin err_n++;
          $display("FAIL rand%0d_burst: span %0d writes %0d ok at %0d want contiguous, ok at %0d",
                   f, last_we - first_we + 1, n_w, ok_cyc, last_we + 1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_timeout();
    test_wrap();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
    $finish;
  end
endmodule
